// File: rtl/mmio_controller.sv
`default_nettype none
// ============================================================================
// Module   : mmio_controller
// Purpose  : CPU data-address decoder for program/sprite/tile/palette RAM and
//            an MMIO register window with frame counter and vblank interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_controller #(
    parameter int          DATA_W       = 16,
    parameter logic [15:0] SPRITE_BASE  = 16'h2000,
    parameter logic [15:0] TILE_BASE    = 16'h2400,
    parameter logic [15:0] PALETTE_BASE = 16'h4400,
    parameter logic [15:0] IO_BASE      = 16'h4800,
    parameter int          IO_SPAN      = 16,
    parameter int          SPR_AW       = 10,
    parameter int          TILE_AW      = 13,
    parameter int          PAL_AW       = 10,
    parameter int          PROG_AW      = 13,
    parameter int          NUM_CTRL     = 4,
    parameter int          SW_W         = 4,
    parameter int          LED_W        = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                memaddr,
    input  logic                       memwrite,
    input  logic [DATA_W-1:0]          writedata,
    output logic [DATA_W-1:0]          memdata,
    output logic                       prog_en,
    output logic                       sprite_en,
    output logic                       tile_en,
    output logic                       palette_en,
    output logic [PROG_AW-1:0]         prog_addr,
    output logic [SPR_AW-1:0]          sprite_addr,
    output logic [TILE_AW-1:0]         tile_addr,
    output logic [PAL_AW-1:0]          palette_addr,
    input  logic [DATA_W-1:0]          prog_rdata,
    input  logic [DATA_W-1:0]          sprite_rdata,
    input  logic [DATA_W-1:0]          tile_rdata,
    input  logic [DATA_W-1:0]          palette_rdata,
    input  logic                       hbright,
    input  logic                       vbright,
    input  logic [SW_W-1:0]            switches,
    output logic [LED_W-1:0]           leds,
    output logic [NUM_CTRL*DATA_W-1:0] ctrl_regs,
    output logic                       vblank_irq
);

    localparam logic [16:0] c_io_end = {1'b0, IO_BASE} + 17'(IO_SPAN);

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_PROG = 3'd1,
        SEL_SPR  = 3'd2,
        SEL_TILE = 3'd3,
        SEL_PAL  = 3'd4,
        SEL_IO   = 3'd5
    } sel_t;

    sel_t              r_rd_sel;
    sel_t              w_sel;
    logic              w_io_sel;
    logic              w_io_we;
    logic [15:0]       w_io_off;
    logic [DATA_W-1:0] w_io_rdata;
    logic [DATA_W-1:0] r_io_rdata;
    logic              w_vblank_start;

    logic              r_hb_m, r_hb_s;
    logic              r_vb_m, r_vb_s, r_vb_d;
    logic [SW_W-1:0]   r_sw_m, r_sw_s;

    logic              r_pending;
    logic              r_irq_en;
    logic [DATA_W-1:0] r_frame;
    logic [LED_W-1:0]  r_leds;
    logic [DATA_W-1:0] r_ctrl [NUM_CTRL];

    // Half-open, mutually exclusive decode; addresses past the IO window select nothing.
    assign prog_en    = (memaddr < SPRITE_BASE);
    assign sprite_en  = (memaddr >= SPRITE_BASE)  && (memaddr < TILE_BASE);
    assign tile_en    = (memaddr >= TILE_BASE)    && (memaddr < PALETTE_BASE);
    assign palette_en = (memaddr >= PALETTE_BASE) && (memaddr < IO_BASE);
    assign w_io_sel   = ({1'b0, memaddr} >= {1'b0, IO_BASE}) && ({1'b0, memaddr} < c_io_end);

    assign prog_addr    = PROG_AW'(memaddr);
    assign sprite_addr  = SPR_AW'(memaddr - SPRITE_BASE);
    assign tile_addr    = TILE_AW'(memaddr - TILE_BASE);
    assign palette_addr = PAL_AW'(memaddr - PALETTE_BASE);

    assign w_io_off       = memaddr - IO_BASE;
    assign w_io_we        = memwrite && w_io_sel;
    assign w_vblank_start = r_vb_d && !r_vb_s;

    always_comb begin
        w_sel = SEL_NONE;
        if (prog_en)         w_sel = SEL_PROG;
        else if (sprite_en)  w_sel = SEL_SPR;
        else if (tile_en)    w_sel = SEL_TILE;
        else if (palette_en) w_sel = SEL_PAL;
        else if (w_io_sel)   w_sel = SEL_IO;
    end

    always_comb begin
        w_io_rdata = '0;
        case (w_io_off)
            16'd0: w_io_rdata[2:0]      = {r_pending, r_hb_s, r_vb_s};
            16'd1: w_io_rdata[0]        = r_irq_en;
            16'd2: w_io_rdata           = r_frame;
            16'd3: w_io_rdata[SW_W-1:0] = r_sw_s;
            default: begin
                for (int k = 0; k < NUM_CTRL; k++) begin
                    if (w_io_off == 16'(4 + k)) w_io_rdata = r_ctrl[k];
                end
            end
        endcase
    end

    always_comb begin
        case (r_rd_sel)
            SEL_PROG: memdata = prog_rdata;
            SEL_SPR:  memdata = sprite_rdata;
            SEL_TILE: memdata = tile_rdata;
            SEL_PAL:  memdata = palette_rdata;
            SEL_IO:   memdata = r_io_rdata;
            default:  memdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_sel   <= SEL_NONE;
            r_io_rdata <= '0;
            r_hb_m     <= 1'b0;
            r_hb_s     <= 1'b0;
            r_vb_m     <= 1'b0;
            r_vb_s     <= 1'b0;
            r_vb_d     <= 1'b0;
            r_sw_m     <= '0;
            r_sw_s     <= '0;
            r_pending  <= 1'b0;
            r_irq_en   <= 1'b0;
            r_frame    <= '0;
            r_leds     <= '0;
            for (int k = 0; k < NUM_CTRL; k++) r_ctrl[k] <= '0;
        end else begin
            r_rd_sel   <= w_sel;
            r_io_rdata <= w_io_rdata;
            r_hb_m     <= hbright;
            r_hb_s     <= r_hb_m;
            r_vb_m     <= vbright;
            r_vb_s     <= r_vb_m;
            r_vb_d     <= r_vb_s;
            r_sw_m     <= switches;
            r_sw_s     <= r_sw_m;

            // A new vblank beats a same-cycle clear so no interrupt is lost.
            if (w_vblank_start)
                r_pending <= 1'b1;
            else if (w_io_we && w_io_off == 16'd0 && writedata[2])
                r_pending <= 1'b0;

            if (w_io_we && w_io_off == 16'd1)
                r_irq_en <= writedata[0];

            if (w_io_we && w_io_off == 16'd2)
                r_frame <= '0;
            else if (w_vblank_start)
                r_frame <= r_frame + 1'b1;

            if (w_io_we && w_io_off == 16'd3)
                r_leds <= writedata[LED_W-1:0];

            for (int k = 0; k < NUM_CTRL; k++) begin
                if (w_io_we && w_io_off == 16'(4 + k)) r_ctrl[k] <= writedata;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl
            assign ctrl_regs[g*DATA_W +: DATA_W] = r_ctrl[g];
        end
    endgenerate

    assign leds       = r_leds;
    assign vblank_irq = r_pending && r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_mmio_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_controller
// Purpose  : Directed table-driven bench for mmio_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] memaddr;
    logic        memwrite;
    logic [15:0] writedata;
    logic [15:0] memdata;
    logic        prog_en, sprite_en, tile_en, palette_en;
    logic [12:0] prog_addr;
    logic [9:0]  sprite_addr;
    logic [12:0] tile_addr;
    logic [9:0]  palette_addr;
    logic [15:0] prog_rdata, sprite_rdata, tile_rdata, palette_rdata;
    logic        hbright, vbright;
    logic [3:0]  switches;
    logic [7:0]  leds;
    logic [63:0] ctrl_regs;
    logic        vblank_irq;

    int pass_cnt = 0;
    int total    = 0;

    mmio_controller dut (
        .clk(clk), .rst(rst), .memaddr(memaddr), .memwrite(memwrite),
        .writedata(writedata), .memdata(memdata),
        .prog_en(prog_en), .sprite_en(sprite_en), .tile_en(tile_en), .palette_en(palette_en),
        .prog_addr(prog_addr), .sprite_addr(sprite_addr), .tile_addr(tile_addr),
        .palette_addr(palette_addr),
        .prog_rdata(prog_rdata), .sprite_rdata(sprite_rdata), .tile_rdata(tile_rdata),
        .palette_rdata(palette_rdata),
        .hbright(hbright), .vbright(vbright), .switches(switches),
        .leds(leds), .ctrl_regs(ctrl_regs), .vblank_irq(vblank_irq)
    );

    always #5 clk = ~clk;

    // Synchronous RAM models: data = {region tag, zero-extended address}.
    always @(posedge clk) begin
        prog_rdata    <= 16'h2000 | {3'b0, prog_addr};
        sprite_rdata  <= 16'h4000 | {6'b0, sprite_addr};
        tile_rdata    <= 16'h6000 | {3'b0, tile_addr};
        palette_rdata <= 16'h8000 | {6'b0, palette_addr};
    end

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  en;     // {prog, sprite, tile, palette}
        logic [12:0] raddr;  // region-relative address of the selected RAM
        logic [15:0] data;   // memdata one cycle later
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic io_write(input logic [15:0] a, input logic [15:0] d);
        memaddr   = a;
        writedata = d;
        memwrite  = 1'b1;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic io_read(input logic [15:0] a, output logic [15:0] d);
        memaddr = a;
        tick();
        d = memdata;
    endtask

    // Drives one falling vbright edge; returns with vblank_start active this cycle.
    task automatic vb_fall_to_start();
        vbright = 1'b1;
        repeat (4) tick();
        vbright = 1'b0;
        repeat (2) tick();
    endtask

    logic [15:0] rd;
    logic [12:0] sel_addr;

    initial begin
        vecs[0] = '{16'h1FFF, 4'b1000, 13'h1FFF, 16'h3FFF};
        vecs[1] = '{16'h2000, 4'b0100, 13'h0000, 16'h4000};
        vecs[2] = '{16'h23FF, 4'b0100, 13'h03FF, 16'h43FF};
        vecs[3] = '{16'h2400, 4'b0010, 13'h0000, 16'h6000};
        vecs[4] = '{16'h43FF, 4'b0010, 13'h1FFF, 16'h7FFF};
        vecs[5] = '{16'h4400, 4'b0001, 13'h0000, 16'h8000};
        vecs[6] = '{16'h4803, 4'b0000, 13'h0000, 16'h000A};
        vecs[7] = '{16'h480F, 4'b0000, 13'h0000, 16'h0000};
        vecs[8] = '{16'h5000, 4'b0000, 13'h0000, 16'h0000};
        vecs[9] = '{16'h4804, 4'b0000, 13'h0000, 16'h00A5};

        rst = 1'b1; memaddr = 16'h0000; memwrite = 1'b0; writedata = 16'h0000;
        hbright = 1'b0; vbright = 1'b0; switches = 4'hA;
        repeat (3) tick();
        rst = 1'b0;
        memaddr = 16'h5000;
        check("reset_memdata", memdata, 0);
        check("reset_leds", leds, 0);
        check("reset_ctrl", ctrl_regs, 0);
        check("reset_irq", vblank_irq, 0);

        // Ctrl register write, read-during-write returns the old value.
        io_write(16'h4804, 16'h00A5);
        check("rdw_old_value", memdata, 16'h0000);
        tick();
        check("ctrl0_read", memdata, 16'h00A5);
        check("ctrl0_port", ctrl_regs[15:0], 16'h00A5);

        for (int i = 0; i < 10; i++) begin
            memaddr = vecs[i].addr;
            #1;
            check($sformatf("en_%h", vecs[i].addr),
                  {prog_en, sprite_en, tile_en, palette_en}, vecs[i].en);
            case (vecs[i].en)
                4'b1000: sel_addr = prog_addr;
                4'b0100: sel_addr = {3'b0, sprite_addr};
                4'b0010: sel_addr = tile_addr;
                4'b0001: sel_addr = {3'b0, palette_addr};
                default: sel_addr = 13'h0;
            endcase
            if (vecs[i].en != 4'b0000)
                check($sformatf("raddr_%h", vecs[i].addr), sel_addr, vecs[i].raddr);
            tick();
            check($sformatf("memdata_%h", vecs[i].addr), memdata, vecs[i].data);
        end

        // Three vblank edges with the interrupt enabled.
        io_write(16'h4801, 16'h0001);
        memaddr = 16'h5000;
        vbright = 1'b1;
        repeat (4) tick();
        vbright = 1'b0;
        repeat (2) tick();
        check("irq_before_3cyc", vblank_irq, 0);
        tick();
        check("irq_after_3cyc", vblank_irq, 1);
        vb_fall_to_start();
        tick();
        vb_fall_to_start();
        tick();
        io_read(16'h4802, rd);
        check("frame_cnt_3", rd, 16'h0003);
        io_read(16'h4800, rd);
        check("status_pending", rd, 16'h0004);
        io_write(16'h4800, 16'h0004);
        check("irq_cleared", vblank_irq, 0);

        // FRAME_CNT write coinciding with vblank_start: count goes to 0.
        memaddr = 16'h5000;
        vb_fall_to_start();
        io_write(16'h4802, 16'h1234);
        io_read(16'h4802, rd);
        check("frame_write_wins", rd, 16'h0000);

        // STATUS clear coinciding with vblank_start: set wins.
        io_write(16'h4800, 16'h0004);
        check("pre_clear", vblank_irq, 0);
        memaddr = 16'h5000;
        vb_fall_to_start();
        io_write(16'h4800, 16'h0004);
        check("set_beats_clear", vblank_irq, 1);
        io_read(16'h4802, rd);
        check("frame_after_set", rd, 16'h0001);

        io_write(16'h4803, 16'h00FF);
        check("leds_ff", leds, 8'hFF);

        io_write(16'h4805, 16'h1111);
        io_write(16'h4806, 16'h2222);
        io_write(16'h4807, 16'h3333);
        check("ctrl_all", ctrl_regs, 64'h3333_2222_1111_00A5);

        // Reset with a same-cycle write that must be discarded.
        memaddr = 16'h4804; writedata = 16'hBEEF; memwrite = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; memwrite = 1'b0;
        check("rst_leds", leds, 0);
        check("rst_ctrl", ctrl_regs, 0);
        check("rst_irq", vblank_irq, 0);
        check("rst_memdata", memdata, 0);
        io_read(16'h4802, rd);
        check("rst_frame", rd, 16'h0000);
        io_read(16'h4801, rd);
        check("rst_irq_en", rd, 16'h0000);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
`default_nettype wire
